// File: rtl/axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem
//
// AXI4 memory slave backed by a DEPTH x DATA_W word array. The write path
// (AW/W/B) and the read path (AR/R) are separate FSMs that run concurrently.
//
// Parameters
//   ID_W   : width of AWID/BID/ARID/RID
//   ADDR_W : byte address width
//   DATA_W : data width, 32 or 64
//   DEPTH  : memory size in DATA_W words
//
// Ports
//   ACLK, ARESET            : clock and synchronous active-high reset
//   AW*                     : write address channel (ID, addr, len, size, burst)
//   W*                      : write data channel (data, byte strobes, last)
//   B*                      : write response channel
//   AR*                     : read address channel
//   R*                      : read data channel
//
// Responses are SLVERR when the transfer size is not the full bus width, the
// burst type is unsupported, the start address is beyond DEPTH, or (writes
// only) WLAST does not line up with AWLEN. Size and burst-type errors block
// every memory write of the burst; errored read bursts return zero data.
// INCR addresses wrap modulo DEPTH and do not honour 4KB boundaries.
//
// Build option
//   AXI4_SLAVE_MEM_WRAP_EN : when defined, WRAP bursts of 2/4/8/16 beats are
//                            supported; otherwise WRAP bursts get SLVERR.
// ---------------------------------------------------------------------------
module axi4_slave_mem #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // write address channel
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    // write data channel
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    // write response channel
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    // read address channel
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    // read data channel
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int STRB_W     = DATA_W / 8;
    localparam int BYTES_LOG2 = $clog2(STRB_W);
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4_SLAVE_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic burst_ok(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len;
        wrap_len = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == BURST_INCR) || (WRAP_EN && (burst == BURST_WRAP) && wrap_len);
    endfunction

    function automatic logic size_ok(input logic [2:0] size);
        return size == 3'(BYTES_LOG2);
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr >> BYTES_LOG2) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr >> BYTES_LOG2) % ADDR_W'(DEPTH));
    endfunction

    // Next beat address. WRAP keeps the upper bits of the aligned
    // (len+1)*STRB_W window and lets only the low bits roll over. A WRAP
    // burst that is not supported is already flagged as an error with its
    // data suppressed, so its address sequence never reaches memory.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0]        burst,
                                                    input logic [7:0]        len);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = (addr & ~ADDR_W'(STRB_W - 1)) + ADDR_W'(STRB_W);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << BYTES_LOG2) - ADDR_W'(1);
        if (burst == BURST_WRAP) begin
            return (addr & ~mask) | (inc & mask);
        end
        return inc;
    endfunction

    // -----------------------------------------------------------------------
    // Storage (never reset)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Write path state
    // -----------------------------------------------------------------------
    logic [1:0]        w_state_q, w_state_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        aw_len_q, aw_len_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_supp_q, w_supp_d;

    logic              aw_hs, w_hs, b_hs;
    logic              aw_err, aw_supp, w_len_err;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;

    assign aw_hs = AWVALID && (w_state_q == W_IDLE);
    assign w_hs  = WVALID  && (w_state_q == W_DATA);
    assign b_hs  = BREADY  && (w_state_q == W_RESP);

    assign aw_supp = !size_ok(AWSIZE) || !burst_ok(AWBURST, AWLEN);
    assign aw_err  = aw_supp || !addr_ok(AWADDR);

    // WLAST must arrive exactly on beat AWLEN+1; an early WLAST or a missing
    // one at the expected beat both mark the burst as errored.
    assign w_len_err = WLAST ? (w_cnt_q != aw_len_q) : (w_cnt_q == aw_len_q);

    assign mem_we   = w_hs && !w_supp_q && !ARESET;
    assign mem_widx = word_idx(w_addr_q);

    always_comb begin
        w_state_d  = w_state_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        aw_id_d    = aw_id_q;
        w_addr_d   = w_addr_q;
        aw_len_d   = aw_len_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        w_supp_d   = w_supp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_id_d    = AWID;
                    w_addr_d   = AWADDR;
                    aw_len_d   = AWLEN;
                    aw_burst_d = AWBURST;
                    w_cnt_d    = 8'd0;
                    w_err_d    = aw_err;
                    w_supp_d   = aw_supp;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_addr_d = next_addr(w_addr_q, aw_burst_q, aw_len_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_err_d  = w_err_q || w_len_err;
                    if (WLAST) begin
                        b_id_d    = aw_id_q;
                        b_resp_d  = (w_err_q || w_len_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem[mem_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path state
    // -----------------------------------------------------------------------
    logic [0:0]        r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              r_last_q, r_last_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_err_q, r_err_d;

    logic              ar_hs, r_hs, ar_err;

    assign ar_hs  = ARVALID && (r_state_q == R_IDLE);
    assign r_hs   = RREADY && r_valid_q;
    assign ar_err = !size_ok(ARSIZE) || !burst_ok(ARBURST, ARLEN) || !addr_ok(ARADDR);

    // RDATA is captured from memory when a beat is launched, so a write
    // landing on the same word in the same cycle is not visible to that beat.
    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_resp_d   = r_resp_q;
        r_data_d   = r_data_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_addr_d   = r_addr_q;
        ar_len_d   = ar_len_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_err_d    = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d     = ARID;
                    ar_len_d   = ARLEN;
                    ar_burst_d = ARBURST;
                    r_err_d    = ar_err;
                    r_cnt_d    = 8'd0;
                    r_resp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    r_data_d   = ar_err ? '0 : mem[word_idx(ARADDR)];
                    r_addr_d   = next_addr(ARADDR, ARBURST, ARLEN);
                    r_valid_d  = 1'b1;
                    r_last_d   = (ARLEN == 8'd0);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_data_d = r_err_q ? '0 : mem[word_idx(r_addr_q)];
                        r_addr_d = next_addr(r_addr_q, ar_burst_q, ar_len_q);
                        r_last_d = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers: FSMs and visible outputs are reset, burst bookkeeping is not
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
            b_resp_q  <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
        end
    end

    always_ff @(posedge ACLK) begin
        aw_id_q    <= aw_id_d;
        w_addr_q   <= w_addr_d;
        aw_len_q   <= aw_len_d;
        aw_burst_q <= aw_burst_d;
        w_cnt_q    <= w_cnt_d;
        w_err_q    <= w_err_d;
        w_supp_q   <= w_supp_d;
        r_addr_q   <= r_addr_d;
        ar_len_q   <= ar_len_d;
        ar_burst_q <= ar_burst_d;
        r_cnt_q    <= r_cnt_d;
        r_err_q    <= r_err_d;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign AWREADY = (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = b_id_q;
    assign BRESP   = b_resp_q;

    assign ARREADY = (r_state_q == R_IDLE);
    assign RVALID  = r_valid_q;
    assign RLAST   = r_last_q;
    assign RID     = r_id_q;
    assign RRESP   = r_resp_q;
    assign RDATA   = r_data_q;

endmodule
